obr_write_arbiter: RTL and testbench

- Shares a bank of NREG one-bit registers between NREQ requesters.
- Each register cell is load-enabled: it holds its value unless its write enable is asserted at the clock edge.
- A round-robin arbiter grants one requester per transaction. A two-state FSM sequences the selected cell's write enable.
- Sits between independent bit producers (e.g. status/flag writers) and the shared flag bank; a combinational read port exposes stored bits.

---
 rtl/obr_arb_pkg.sv | 33 +++
 rtl/obr_bit_cell.sv | 15 +
 rtl/obr_write_arbiter.sv | 121 ++++++++++++
 tb/tb_obr_write_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obr_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for obr_write_arbiter.
package obr_arb_pkg;

  localparam int unsigned OBR_NREQ_DEF = 4;
  localparam int unsigned OBR_NREG_DEF = 8;
  localparam int unsigned OBR_MAX_REQ  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } obr_state_e;

  // First set request at or after ptr, wrapping modulo nreq.
  function automatic logic [2:0] rr_pick(input logic [OBR_MAX_REQ-1:0] req,
                                         input logic [2:0]             ptr,
                                         input int unsigned            nreq);
    logic        found;
    int unsigned idx;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < OBR_MAX_REQ; i++) begin
      if (i < nreq) begin
        idx = 32'(ptr) + i;
        if (idx >= nreq) idx = idx - nreq;
        if (!found && req[idx]) begin
          rr_pick = 3'(idx);
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/obr_bit_cell.sv
// One load-enabled flag bit with asynchronous active-low clear.
module obr_bit_cell (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/obr_write_arbiter.sv
// Round-robin write arbiter in front of a bank of one-bit flag cells.
// Optional OBR_ARB_LOCK_EN adds a per-requester lock that holds priority on the granted requester.
module obr_write_arbiter
  import obr_arb_pkg::*;
#(
  parameter int unsigned NREQ = OBR_NREQ_DEF,
  parameter int unsigned NREG = OBR_NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] wr_addr,
  input  logic [NREQ-1:0]   wr_data,
`ifdef OBR_ARB_LOCK_EN
  input  logic [NREQ-1:0]   lock,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              wr_err,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_data,
  output logic [NREG-1:0]   reg_q
);

  localparam int unsigned PW = $clog2(NREQ);

  obr_state_e              state_q, state_d;
  logic [PW-1:0]           ptr_q, ptr_d;
  logic [NREQ-1:0]         gnt_q, gnt_d;
  logic [AW-1:0]           lat_addr_q, lat_addr_d;
  logic                    lat_data_q, lat_data_d;
  logic                    err_q, err_d;
  logic [OBR_MAX_REQ-1:0]  req_ext;
  logic [PW-1:0]           k_idx;
  logic [NREG-1:0]         we;
  logic [(2**AW)-1:0]      reg_pad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      lat_addr_q <= '0;
      lat_data_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    err_d      = 1'b0;
    req_ext    = '0;
    req_ext[NREQ-1:0] = req;
    k_idx      = PW'(rr_pick(req_ext, 3'(ptr_q), NREQ));
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = WRITE;
          gnt_d   = '0;
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (k_idx == PW'(i)) begin
              gnt_d[i]   = 1'b1;
              lat_addr_d = wr_addr[i*AW +: AW];
              lat_data_d = wr_data[i];
              ptr_d      = (i == NREQ - 1) ? '0 : PW'(i + 1);
`ifdef OBR_ARB_LOCK_EN
              if (lock[i]) ptr_d = PW'(i);
`endif
            end
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
        gnt_d   = '0;
        err_d   = (32'(lat_addr_q) >= NREG);
      end
    endcase
  end

  always_comb begin
    busy = (state_q == WRITE);
    we   = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      we[i] = (state_q == WRITE) && (lat_addr_q == AW'(i));
    end
  end

  assign gnt    = gnt_q;
  assign wr_err = err_q;

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    obr_bit_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .we    (we[g]),
      .d     (lat_data_q),
      .q     (reg_q[g])
    );
  end

  // Zero-padded so addresses past NREG read back 0 without a range compare.
  always_comb begin
    reg_pad              = '0;
    reg_pad[NREG-1:0]    = reg_q;
    rd_data              = reg_pad[rd_addr];
  end

endmodule

// File: tb/tb_obr_write_arbiter.sv
// Scoreboard bench for obr_write_arbiter (NREQ=4, NREG=6); lock test only with OBR_ARB_LOCK_EN.
module tb_obr_write_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NREG = 6;
  localparam int unsigned AW   = 3;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [NREG-1:0] regv;
    logic            err;
  } exp_t;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] wr_addr;
  logic [NREQ-1:0]   wr_data;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              wr_err;
  logic [AW-1:0]     rd_addr;
  logic              rd_data;
  logic [NREG-1:0]   reg_q;
`ifdef OBR_ARB_LOCK_EN
  logic [NREQ-1:0]   lock;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  obr_write_arbiter #(.NREQ(NREQ), .NREG(NREG)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`ifdef OBR_ARB_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .busy    (busy),
    .wr_err  (wr_err),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .reg_q   (reg_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [NREQ-1:0] g, input logic [NREG-1:0] r, input logic e);
    exp_t x;
    x.gnt = g; x.regv = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_wr(input int unsigned i, input logic [AW-1:0] a, input logic d);
    wr_addr[i*AW +: AW] = a;
    wr_data[i]          = d;
  endtask

  // Requesters drop their bit on seeing their grant; returns on the commit negedge.
  task automatic do_txn(input logic [NREQ-1:0] r);
    bit done;
    done = 1'b0;
    req  = r;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      req = req & ~gnt;
      if (req == '0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL txn_timeout: got req=%0h expected all granted", req);
      req = '0;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor: every grant pops one expectation; commit is checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (gnt !== '0) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_gnt: got %0h expected none", gnt);
        end else begin
          e = sb.pop_front();
          check("gnt", 32'(gnt), 32'(e.gnt));
          check("busy_write", 32'(busy), 32'd1);
          check("err_during_write", 32'(wr_err), 32'd0);
          @(negedge clk);
          check("reg_q_commit", 32'(reg_q), 32'(e.regv));
          check("wr_err_commit", 32'(wr_err), 32'(e.err));
          check("busy_after", 32'(busy), 32'd0);
          check("gnt_after", 32'(gnt), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset   = 1'b0;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
`ifdef OBR_ARB_LOCK_EN
    lock    = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_reg_q", 32'(reg_q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write with latency and busy-width checks
    set_wr(0, 3'd3, 1'b1);
    push(4'b0001, 6'h08, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    check("lat_gnt", 32'(gnt), 32'b0001);
    check("lat_reg_old", 32'(reg_q), 32'd0);
    req = '0;
    @(negedge clk);
    check("lat_reg_new", 32'(reg_q), 32'h08);
    check("lat_busy_one", 32'(busy), 32'd0);
    rd_addr = 3'd3; #1 check("rd_addr3", 32'(rd_data), 32'd1);
    rd_addr = 3'd2; #1 check("rd_addr2", 32'(rd_data), 32'd0);

    // Contention from a fresh pointer
    reset_pulse();
    for (int unsigned i = 0; i < NREQ; i++) set_wr(i, AW'(i), 1'b1);
    push(4'b0001, 6'h01, 1'b0);
    push(4'b0010, 6'h03, 1'b0);
    push(4'b0100, 6'h07, 1'b0);
    push(4'b1000, 6'h0F, 1'b0);
    do_txn(4'b1111);
    check("contention_final", 32'(reg_q), 32'h0F);

    // Wrap-around: grant 2 moves pointer to 3, then 3 beats 0
    set_wr(2, 3'd4, 1'b0);
    push(4'b0100, 6'h0F, 1'b0);
    do_txn(4'b0100);
    set_wr(0, 3'd5, 1'b1);
    set_wr(3, 3'd4, 1'b1);
    push(4'b1000, 6'h1F, 1'b0);
    push(4'b0001, 6'h3F, 1'b0);
    do_txn(4'b1001);

    // Overwrite 1 with 0
    set_wr(1, 3'd0, 1'b0);
    push(4'b0010, 6'h3E, 1'b0);
    do_txn(4'b0010);

    // Out-of-range addresses
    set_wr(2, 3'd7, 1'b1);
    push(4'b0100, 6'h3E, 1'b1);
    do_txn(4'b0100);
    @(negedge clk);
    check("wr_err_one_cycle", 32'(wr_err), 32'd0);
    rd_addr = 3'd7; #1 check("rd_oor7", 32'(rd_data), 32'd0);
    rd_addr = 3'd5; #1 check("rd_addr5", 32'(rd_data), 32'd1);
    set_wr(3, 3'd6, 1'b1);
    push(4'b1000, 6'h3E, 1'b1);
    do_txn(4'b1000);

    // Reset during WRITE aborts the write
    set_wr(1, 3'd5, 1'b1);
    push(4'b0010, 6'h00, 1'b0);
    req = 4'b0010;
    @(negedge clk);
    #2;
    reset = 1'b0;
    req   = '0;
    #1;
    check("arst_gnt", 32'(gnt), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_wr_err", 32'(wr_err), 32'd0);
    check("arst_reg_q", 32'(reg_q), 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    set_wr(0, 3'd0, 1'b1);
    set_wr(1, 3'd1, 1'b1);
    push(4'b0001, 6'h01, 1'b0);
    push(4'b0010, 6'h03, 1'b0);
    do_txn(4'b0011);

`ifdef OBR_ARB_LOCK_EN
    // Locked requester 0 wins three times before 1 gets a turn
    begin
      int  n0;
      bit  done;
      n0   = 0;
      done = 1'b0;
      set_wr(0, 3'd2, 1'b1);
      set_wr(1, 3'd1, 1'b0);
      push(4'b0001, 6'h07, 1'b0);
      push(4'b0001, 6'h07, 1'b0);
      push(4'b0001, 6'h07, 1'b0);
      push(4'b0010, 6'h05, 1'b0);
      lock = 4'b0001;
      req  = 4'b0011;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (gnt[0]) begin
          n0++;
          if (n0 == 3) begin
            req[0]  = 1'b0;
            lock[0] = 1'b0;
          end
        end
        if (gnt[1]) req[1] = 1'b0;
        if (req == '0) begin
          done = 1'b1;
          break;
        end
      end
      if (!done) begin
        n_cmp++; n_err++;
        $display("FAIL lock_timeout: got req=%0h expected all granted", req);
        req = '0;
      end
      @(negedge clk);
    end
`endif

    for (int c = 0; c < 20 && sb.size() != 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
